// File: rtl/mem_ctrl_arb_pkg.sv
// Shared definitions for the memory controller arbiter: block address/data types,
// request type and the arbiter state/owner encodings.
`timescale 1ns/1ps
package mem_ctrl_arb_pkg;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 64;

   typedef logic [ADDR_W-1:0] main_mem_block_addr_t;
   typedef logic [DATA_W-1:0] block_data_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } req_type_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } arb_owner_t;

   localparam logic [7:0] WAIT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-port (icache/dcache) arbiter in front of a single-outstanding main memory port.
// Optional dcache starvation guard enabled by defining MEM_CTRL_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module mem_ctrl_arb
   import mem_ctrl_arb_pkg::*;
#(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst_aL,
   input  logic                 ic_req_valid,
   input  main_mem_block_addr_t ic_req_block_addr,
   output logic                 ic_req_ready,
   output logic                 ic_resp_valid,
   output block_data_t          ic_resp_block_data,
   input  logic                 dc_req_valid,
   input  req_type_t            dc_req_type,
   input  main_mem_block_addr_t dc_req_block_addr,
   input  block_data_t          dc_req_block_data,
   output logic                 dc_req_ready,
   output logic                 dc_resp_valid,
   output block_data_t          dc_resp_block_data,
   output logic                 mem_req_valid,
   output req_type_t            mem_req_type,
   output main_mem_block_addr_t mem_req_block_addr,
   output block_data_t          mem_req_block_data,
   input  logic                 mem_req_ready,
   input  logic                 mem_resp_valid,
   input  block_data_t          mem_resp_block_data,
   output logic                 arb_timeout_err
);

   // Limits above the 8-bit counter range can never be reached.
   localparam logic [8:0] TIMEOUT_LIM = (TIMEOUT_CYCLES > 255) ? 9'd256 : 9'(TIMEOUT_CYCLES);

   arb_state_t           r_state;
   arb_state_t           w_state_next;
   arb_owner_t           r_owner;
   logic                 r_mem_req_valid;
   req_type_t            r_mem_req_type;
   main_mem_block_addr_t r_mem_req_addr;
   block_data_t          r_mem_req_data;
   logic [7:0]           r_wait_cnt;
   logic [7:0]           w_wait_cnt_inc;
   logic                 r_timeout_err;
   logic                 w_ic_grant;
   logic                 w_dc_grant;
   logic                 w_ic_resp;
   logic                 w_dc_resp;
   logic                 w_dc_first;

`ifdef MEM_CTRL_ARB_STARVE_GUARD_EN
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
   logic [7:0] r_starve_cnt;

   assign w_dc_first = (r_starve_cnt >= STARVE_LIM);

   // Counts back-to-back icache wins while dcache is kept waiting.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_starve_cnt <= '0;
      end else if (w_dc_grant) begin
         r_starve_cnt <= '0;
      end else if (w_ic_grant) begin
         r_starve_cnt <= dc_req_valid ? r_starve_cnt + 8'd1 : 8'd0;
      end
   end
`else
   assign w_dc_first = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ic_grant   = 1'b0;
      w_dc_grant   = 1'b0;
      w_ic_resp    = 1'b0;
      w_dc_resp    = 1'b0;
      case (r_state)
         IDLE: begin
            if (rst_aL) begin
               if (dc_req_valid && (w_dc_first || !ic_req_valid)) w_dc_grant = 1'b1;
               else if (ic_req_valid)                             w_ic_grant = 1'b1;
               if (w_ic_grant || w_dc_grant) w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_req_ready) w_state_next = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid) begin
               w_ic_resp    = (r_owner == OWN_IC);
               w_dc_resp    = (r_owner == OWN_DC);
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_wait_cnt_inc = (r_wait_cnt == WAIT_CNT_MAX) ? r_wait_cnt : r_wait_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_owner         <= OWN_IC;
         r_mem_req_valid <= 1'b0;
         r_mem_req_type  <= READ;
         r_mem_req_addr  <= '0;
         r_mem_req_data  <= '0;
         r_wait_cnt      <= '0;
         r_timeout_err   <= 1'b0;
      end else begin
         if (w_ic_grant) begin
            r_owner         <= OWN_IC;
            r_mem_req_valid <= 1'b1;
            r_mem_req_type  <= READ;
            r_mem_req_addr  <= ic_req_block_addr;
            r_mem_req_data  <= '0;
         end else if (w_dc_grant) begin
            r_owner         <= OWN_DC;
            r_mem_req_valid <= 1'b1;
            r_mem_req_type  <= dc_req_type;
            r_mem_req_addr  <= dc_req_block_addr;
            r_mem_req_data  <= dc_req_block_data;
         end else if (r_state == ISSUE && mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
         end

         if (r_state == ISSUE && mem_req_ready) begin
            r_wait_cnt <= '0;
         end else if (r_state == WAIT) begin
            r_wait_cnt <= w_wait_cnt_inc;
            if ({1'b0, w_wait_cnt_inc} >= TIMEOUT_LIM) r_timeout_err <= 1'b1;
         end
      end
   end

   assign ic_req_ready       = w_ic_grant;
   assign dc_req_ready       = w_dc_grant;
   assign ic_resp_valid      = w_ic_resp;
   assign dc_resp_valid      = w_dc_resp;
   assign ic_resp_block_data = w_ic_resp ? mem_resp_block_data : '0;
   assign dc_resp_block_data = w_dc_resp ? mem_resp_block_data : '0;
   assign mem_req_valid      = r_mem_req_valid;
   assign mem_req_type       = r_mem_req_type;
   assign mem_req_block_addr = r_mem_req_addr;
   assign mem_req_block_data = r_mem_req_data;
   assign arb_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Scoreboard bench for mem_ctrl_arb: grants push expected responses, responses pop and compare.
`timescale 1ns/1ps
module tb_mem_ctrl_arb;
   import mem_ctrl_arb_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_aL;
   logic                 ic_req_valid;
   main_mem_block_addr_t ic_req_block_addr;
   logic                 ic_req_ready;
   logic                 ic_resp_valid;
   block_data_t          ic_resp_block_data;
   logic                 dc_req_valid;
   req_type_t            dc_req_type;
   main_mem_block_addr_t dc_req_block_addr;
   block_data_t          dc_req_block_data;
   logic                 dc_req_ready;
   logic                 dc_resp_valid;
   block_data_t          dc_resp_block_data;
   logic                 mem_req_valid;
   req_type_t            mem_req_type;
   main_mem_block_addr_t mem_req_block_addr;
   block_data_t          mem_req_block_data;
   logic                 mem_req_ready;
   logic                 mem_resp_valid;
   block_data_t          mem_resp_block_data;
   logic                 arb_timeout_err;

   mem_ctrl_arb #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst_aL(rst_aL),
      .ic_req_valid(ic_req_valid), .ic_req_block_addr(ic_req_block_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_block_data(ic_resp_block_data),
      .dc_req_valid(dc_req_valid), .dc_req_type(dc_req_type), .dc_req_block_addr(dc_req_block_addr),
      .dc_req_block_data(dc_req_block_data), .dc_req_ready(dc_req_ready),
      .dc_resp_valid(dc_resp_valid), .dc_resp_block_data(dc_resp_block_data),
      .mem_req_valid(mem_req_valid), .mem_req_type(mem_req_type), .mem_req_block_addr(mem_req_block_addr),
      .mem_req_block_data(mem_req_block_data), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_block_data(mem_resp_block_data),
      .arb_timeout_err(arb_timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_dc;
      bit          chk_data;
      block_data_t data;
   } exp_resp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_resp_t   exp_q[$];
   bit          grant_log[$];
   int          cyc = 0;
   int          ic_resp_cyc = -1;
   int          dc_grant_cyc = -1;
   int          mreq_run = 0;
   int          last_mreq_run = 0;
   bit          mexp_valid = 0;
   req_type_t   mexp_type = READ;
   main_mem_block_addr_t mexp_addr = '0;
   block_data_t mexp_data = '0;
   int          cfg_lat = 0;
   int          cfg_stall = 0;
   bit          cfg_mute = 0;
   int          stray_req = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic block_data_t rd_pat(input main_mem_block_addr_t a);
      return {12'hA5C, a, a ^ 26'h155_5555};
   endfunction

   // Monitor: samples on the falling edge, records grants, checks memory requests and responses.
   initial begin
      exp_resp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_aL) begin
            exp_q.delete();
            mexp_valid = 0;
            mreq_run   = 0;
            continue;
         end
         if (ic_req_valid && ic_req_ready) begin
            exp_q.push_back('{is_dc: 1'b0, chk_data: 1'b1, data: rd_pat(ic_req_block_addr)});
            grant_log.push_back(1'b0);
            mexp_valid = 1; mexp_type = READ; mexp_addr = ic_req_block_addr; mexp_data = '0;
            $display("[%0d] grant IC READ  addr=%h", cyc, ic_req_block_addr);
         end
         if (dc_req_valid && dc_req_ready) begin
            exp_q.push_back('{is_dc: 1'b1, chk_data: (dc_req_type == READ), data: rd_pat(dc_req_block_addr)});
            grant_log.push_back(1'b1);
            dc_grant_cyc = cyc;
            mexp_valid = 1; mexp_type = dc_req_type; mexp_addr = dc_req_block_addr; mexp_data = dc_req_block_data;
            $display("[%0d] grant DC %s addr=%h", cyc, dc_req_type.name(), dc_req_block_addr);
         end
         if (mem_req_valid) begin
            mreq_run++;
            if (!mexp_valid) begin
               check_eq("mem_req_unexpected", 64'(mem_req_valid), 64'd0);
            end else begin
               check_eq("mem_req_addr", 64'(mem_req_block_addr), 64'(mexp_addr));
               check_eq("mem_req_type", 64'(mem_req_type), 64'(mexp_type));
               if (mexp_type == WRITE) check_eq("mem_req_data", mem_req_block_data, mexp_data);
            end
         end else if (mreq_run > 0) begin
            last_mreq_run = mreq_run;
            mreq_run      = 0;
         end
         if (ic_resp_valid || dc_resp_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("resp_unexpected", {62'd0, ic_resp_valid, dc_resp_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("resp_owner", {62'd0, ic_resp_valid, dc_resp_valid}, e.is_dc ? 64'd1 : 64'd2);
               if (e.chk_data) check_eq("resp_data", e.is_dc ? dc_resp_block_data : ic_resp_block_data, e.data);
               if (ic_resp_valid) ic_resp_cyc = cyc;
               mexp_valid = 0;
               $display("[%0d] resp %s data=%h", cyc, ic_resp_valid ? "IC" : "DC",
                        ic_resp_valid ? ic_resp_block_data : dc_resp_block_data);
            end
         end
      end
   end

   // Main-memory model: optional accept stall, response latency, mute, and stray responses.
   initial begin
      int  stall_left = 0;
      int  delay = 0;
      int  stray_done = 0;
      bit  busy = 0;
      bit  accepting = 0;
      bit  stall_armed = 0;
      bit  m_wr = 0;
      main_mem_block_addr_t m_addr = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_block_data = '0;
      forever begin
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         mem_resp_block_data = '0;
         if (accepting) begin
            accepting = 0; mem_req_ready = 1'b0; busy = 1; delay = cfg_lat;
         end
         if (busy) begin
            if (!cfg_mute) begin
               if (delay > 0) delay--;
               else begin
                  mem_resp_valid = 1'b1;
                  mem_resp_block_data = m_wr ? 64'hFFFF_0000_DEAD_BEEF : rd_pat(m_addr);
                  busy = 0;
               end
            end
         end else if (stray_req != stray_done) begin
            stray_done++;
            mem_resp_valid = 1'b1;
            mem_resp_block_data = 64'h5A5A_5A5A_5A5A_5A5A;
         end else if (mem_req_valid) begin
            if (!stall_armed) begin stall_left = cfg_stall; stall_armed = 1; end
            if (stall_left > 0) begin
               stall_left--;
               mem_req_ready = 1'b0;
            end else begin
               mem_req_ready = 1'b1; accepting = 1; stall_armed = 0;
               m_wr = (mem_req_type == WRITE); m_addr = mem_req_block_addr;
            end
         end
      end
   end

   task automatic ic_request(input main_mem_block_addr_t a);
      bit ok = 0;
      @(posedge clk); #1;
      ic_req_valid = 1'b1; ic_req_block_addr = a;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (ic_req_ready) begin ok = 1; break; end
      end
      check_eq("ic_granted", 64'(ok), 64'd1);
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
   endtask

   task automatic dc_request(input req_type_t t, input main_mem_block_addr_t a, input block_data_t d);
      bit ok = 0;
      @(posedge clk); #1;
      dc_req_valid = 1'b1; dc_req_type = t; dc_req_block_addr = a; dc_req_block_data = d;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (dc_req_ready) begin ok = 1; break; end
      end
      check_eq("dc_granted", 64'(ok), 64'd1);
      @(posedge clk); #1;
      dc_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mem_req_valid) begin done = 1; break; end
      end
      check_eq("idle_reached", 64'(done), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      bit saw;
      bit dc_gr;
      int base;
      bit exp_seq [6];
`ifdef MEM_CTRL_ARB_STARVE_GUARD_EN
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      rst_aL = 1'b0;
      ic_req_valid = 1'b1; ic_req_block_addr = 26'h10;
      dc_req_valid = 1'b1; dc_req_type = READ; dc_req_block_addr = 26'h20; dc_req_block_data = '0;

      // Reset state, with both requesters valid.
      repeat (3) @(negedge clk);
      check_eq("rst_ic_ready", 64'(ic_req_ready), 64'd0);
      check_eq("rst_dc_ready", 64'(dc_req_ready), 64'd0);
      check_eq("rst_mem_valid", 64'(mem_req_valid), 64'd0);
      check_eq("rst_mem_addr", 64'(mem_req_block_addr), 64'd0);
      check_eq("rst_resp_valid", {62'd0, ic_resp_valid, dc_resp_valid}, 64'd0);
      check_eq("rst_timeout_err", 64'(arb_timeout_err), 64'd0);
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      @(posedge clk); #1;
      rst_aL = 1'b1;
      repeat (2) @(negedge clk);

      // Simultaneous requests: icache wins, dcache follows in the first IDLE after the response.
      @(posedge clk); #1;
      ic_req_valid = 1'b1; ic_req_block_addr = 26'h10;
      dc_req_valid = 1'b1; dc_req_type = READ; dc_req_block_addr = 26'h20;
      @(negedge clk);
      check_eq("simul_ic_ready", 64'(ic_req_ready), 64'd1);
      check_eq("simul_dc_ready", 64'(dc_req_ready), 64'd0);
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
      @(negedge clk);
      check_eq("simul_mem_valid", 64'(mem_req_valid), 64'd1);
      check_eq("simul_mem_addr", 64'(mem_req_block_addr), 64'h10);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (dc_req_ready) begin ok = 1; break; end
      end
      check_eq("simul_dc_granted", 64'(ok), 64'd1);
      @(posedge clk); #1;
      dc_req_valid = 1'b0;
      wait_idle();
      check_eq("dc_first_idle_grant", 64'(dc_grant_cyc), 64'(ic_resp_cyc + 1));

      // dcache write with memory stalling acceptance for 3 cycles.
      cfg_stall = 3;
      dc_request(WRITE, 26'h7, 64'hCAFE_F00D_1234_5678);
      wait_idle();
      check_eq("write_req_cycles", 64'(last_mreq_run), 64'd4);
      cfg_stall = 0;

      // Stray memory response while IDLE must be ignored.
      @(posedge clk); #1;
      stray_req++;
      saw = 0;
      repeat (3) begin
         @(negedge clk);
         saw |= mem_resp_valid;
         check_eq("stray_resp_valid", {62'd0, ic_resp_valid, dc_resp_valid}, 64'd0);
      end
      check_eq("stray_injected", 64'(saw), 64'd1);
      @(posedge clk); #1;
      ic_req_valid = 1'b1; ic_req_block_addr = 26'h3A;
      @(negedge clk);
      check_eq("stray_still_idle", 64'(ic_req_ready), 64'd1);
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
      wait_idle();

      // Mixed traffic with random latencies and stalls.
      for (int i = 0; i < 6; i++) begin
         cfg_lat   = $urandom_range(0, 3);
         cfg_stall = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1)
            ic_request(main_mem_block_addr_t'($urandom));
         else
            dc_request(req_type_t'($urandom_range(0, 1)), main_mem_block_addr_t'($urandom), {$urandom, $urandom});
         wait_idle();
      end
      cfg_lat = 0; cfg_stall = 0;

      // Both requesters held valid: grant order depends on the starvation guard.
      base = grant_log.size();
      dc_gr = 0;
      @(posedge clk); #1;
      ic_req_valid = 1'b1; ic_req_block_addr = 26'h40;
      dc_req_valid = 1'b1; dc_req_type = READ; dc_req_block_addr = 26'h80;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (dc_req_valid && dc_req_ready) dc_gr = 1;
         @(posedge clk); #1;
         if (dc_gr) dc_req_valid = 1'b0;
         if (grant_log.size() - base >= 6) break;
      end
      ic_req_valid = 1'b0;
      check_eq("starve_grant_count", 64'(grant_log.size() - base), 64'd6);
      for (int j = 0; j < 6; j++)
         if (grant_log.size() > base + j)
            check_eq($sformatf("starve_grant_%0d", j), 64'(grant_log[base + j]), 64'(exp_seq[j]));
      for (int k = 0; k < 50 && !dc_gr; k++) begin
         @(negedge clk);
         if (dc_req_valid && dc_req_ready) dc_gr = 1;
      end
      check_eq("starve_dc_served", 64'(dc_gr), 64'd1);
      @(posedge clk); #1;
      dc_req_valid = 1'b0;
      wait_idle();

      // No memory response: timeout flag sets near 255 WAIT cycles and is sticky.
      cfg_mute = 1;
      ic_request(26'h55);
      repeat (200) @(negedge clk);
      check_eq("timeout_early", 64'(arb_timeout_err), 64'd0);
      repeat (80) @(negedge clk);
      check_eq("timeout_set", 64'(arb_timeout_err), 64'd1);
      check_eq("timeout_still_waiting", 64'(ic_resp_valid), 64'd0);
      @(posedge clk); #1;
      cfg_mute = 0;
      wait_idle();
      check_eq("timeout_sticky", 64'(arb_timeout_err), 64'd1);

      // Reset during WAIT abandons the transaction; the late response is dropped.
      cfg_mute = 1;
      dc_request(READ, 26'h33, '0);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      rst_aL = 1'b0;
      #1;
      check_eq("midrst_mem_valid", 64'(mem_req_valid), 64'd0);
      check_eq("midrst_mem_addr", 64'(mem_req_block_addr), 64'd0);
      check_eq("midrst_ready", {62'd0, ic_req_ready, dc_req_ready}, 64'd0);
      check_eq("midrst_timeout_err", 64'(arb_timeout_err), 64'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_aL = 1'b1;
      cfg_mute = 0;
      saw = 0;
      repeat (3) begin
         @(negedge clk);
         saw |= mem_resp_valid;
         check_eq("late_resp_dropped", {62'd0, ic_resp_valid, dc_resp_valid}, 64'd0);
      end
      check_eq("late_resp_injected", 64'(saw), 64'd1);
      ic_request(26'h99);
      wait_idle();
      check_eq("post_rst_timeout_err", 64'(arb_timeout_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_arb.md
MEM_CTRL_ARB -- requirements
Module: mem_ctrl_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive icache grants while dcache waits (used only with MEM_CTRL_ARB_STARVE_GUARD_EN).
REQ-002 Parameter TIMEOUT_CYCLES, default 255: max cycles in WAIT before the error flag sets.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_aL  in  1  asynchronous, active-low reset.
REQ-005 ic_req_valid  in  1  icache block read request.
REQ-006 ic_req_block_addr  in  main_mem_block_addr_t  icache block address.
REQ-007 ic_req_ready  out  1  icache request accepted this cycle.
REQ-008 ic_resp_valid  out  1  icache fill data valid, single-cycle pulse.
REQ-009 ic_resp_block_data  out  block_data_t  icache fill data.
REQ-010 dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data  in  1/req_type_t/main_mem_block_addr_t/block_data_t  dcache request.
REQ-011 dc_req_ready  out  1  dcache request accepted this cycle.
REQ-012 dc_resp_valid, dc_resp_block_data  out  1/block_data_t  dcache read data or write ack.
REQ-013 mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data  out  1/req_type_t/main_mem_block_addr_t/block_data_t  request to main memory; all registered.
REQ-014 mem_req_ready  in  1  main memory accepts the request.
REQ-015 mem_resp_valid, mem_resp_block_data  in  1/block_data_t  main memory response, one per accepted request.
REQ-016 arb_timeout_err  out  1  sticky: outstanding request exceeded TIMEOUT_CYCLES.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT; exactly one outstanding memory transaction at any time.
REQ-018 In IDLE, ready SHALL be asserted combinationally to exactly one valid requester; icache has fixed priority; with no valid requester both readies stay 0.
REQ-019 On a grant in IDLE, the arbiter SHALL latch the owner (IC/DC), type, address and data, and transition to ISSUE next cycle.
REQ-020 An icache grant SHALL always carry type READ; the icache write data is don't-care.
REQ-021 In ISSUE, mem_req_valid SHALL be 1 with the latched fields; it SHALL hold stable until mem_req_ready is 1; on handshake the FSM goes to WAIT.
REQ-022 In WAIT, mem_resp_valid SHALL be routed combinationally, in the same cycle, to the latched owner only, with data forwarded unchanged; the FSM returns to IDLE next cycle.
REQ-023 A dcache WRITE SHALL complete with dc_resp_valid=1 as ack; dc_resp_block_data is don't-care for writes.
REQ-024 The arbiter SHALL NOT grant in the cycle of a response; earliest next grant is the first IDLE cycle (request-to-request spacing is at least 3 cycles).
REQ-025 mem_resp_valid outside WAIT SHALL be ignored; both resp_valid outputs stay 0.
REQ-026 An 8-bit wait counter SHALL clear on entering WAIT, increment each WAIT cycle, and saturate; on reaching TIMEOUT_CYCLES it SHALL set arb_timeout_err (sticky until reset), and the FSM SHALL keep waiting.
REQ-027 Requester valid deasserted after grant SHALL NOT cancel the transaction.

Reset
REQ-028 rst_aL low SHALL asynchronously force IDLE, clear the owner, latched fields, wait counter, starvation counter and arb_timeout_err; all outputs 0.
REQ-029 Reset mid-transaction SHALL abandon it; a late mem_resp_valid after reset SHALL be dropped per REQ-025.

Configuration
REQ-030 Macro MEM_CTRL_ARB_STARVE_GUARD_EN defined: a counter SHALL count consecutive icache grants made while dc_req_valid=1; at STARVE_LIMIT the next IDLE grant SHALL go to dcache and the counter SHALL clear; the counter SHALL also clear on any dcache grant.
REQ-031 Macro undefined: strict icache priority, no counter logic; ic_req_ready SHALL equal ic_req_valid in every IDLE cycle.

Structure
REQ-032 main_mem_block_addr_t, block_data_t, req_type_t (READ/WRITE) and the arb state enum SHALL live in the shared global definitions package.
REQ-033 A single flat module; no sub-modules.

Verification
REQ-034 Simultaneous ic and dc valid in IDLE, addr 0x10/0x20 -> ic_req_ready=1, dc_req_ready=0; mem_req_block_addr=0x10 the next cycle; dc is granted in the first IDLE after the ic response.
REQ-035 dc WRITE at addr 0x7, mem_req_ready held 0 for 3 cycles -> mem_req fields stable for 4 cycles; mem_resp_valid produces dc_resp_valid=1 and ic_resp_valid=0.
REQ-036 Stray mem_resp_valid in IDLE -> no resp_valid output; FSM stays IDLE.
REQ-037 With the guard macro and STARVE_LIMIT=4, ic and dc both held valid -> grant sequence IC,IC,IC,IC,DC,IC...
REQ-038 No mem response for 255 WAIT cycles -> arb_timeout_err=1 and stays 1 after a later response; clears only on rst_aL.
REQ-039 rst_aL pulsed low in WAIT -> outputs 0 immediately; the following mem_resp_valid is dropped; a new ic request is granted normally.
